multicycle_controller: RTL

- Multi-cycle control FSM for the RV32I core variant that shares one ALU and one unified instruction/data memory port across several cycles per instruction.
- Consumes the latched instruction opcode and the ALU Zero flag, and emits per-state mux selects and write enables to the datapath.
- Inserts wait states on a simple memory ready handshake and counts retired instructions.
- Replaces the single-cycle decoder path for the multi-cycle build.

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/imm_src_decoder.sv | 24 ++
 rtl/multicycle_controller.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control path.
package mc_pkg;

  // Controller states; 16 states fill the 4-bit encoding exactly.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_JALRPC   = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_LUI      = 4'd14,
    ST_TRAP     = 4'd15
  } state_t;

  // Supported opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A mux.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B mux.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Immediate format.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode -> immediate format, plus a flag saying the opcode is supported.
module imm_src_decoder
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [2:0] imm_src_o,
  output logic       legal_o
);

  // Pure lookup; unsupported opcodes fall back to I format and clear legal_o.
  always_comb begin
    imm_src_o = IMM_I;
    legal_o   = 1'b1;
    case (op_i)
      OP_LOAD, OP_JALR, OP_ITYPE, OP_RTYPE: imm_src_o = IMM_I;
      OP_STORE:                             imm_src_o = IMM_S;
      OP_BRANCH:                            imm_src_o = IMM_B;
      OP_JAL:                               imm_src_o = IMM_J;
      OP_AUIPC, OP_LUI:                     imm_src_o = IMM_U;
      default:                              legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: per-state datapath selects, memory wait states,
// sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrRet
);

  state_t             state_q, state_d;
  logic               illegal_q;
  logic [CNT_W-1:0]   instr_ret_q;
  logic               retire_c;
  logic               legal_c;

  imm_src_decoder u_imm_src_decoder (
    .op_i      (op),
    .imm_src_o (ImmSrc),
    .legal_o   (legal_c)
  );

  assign Illegal  = illegal_q;
  assign InstrRet = instr_ret_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Sticky trap flag and retire counter; the flag rises on entry to TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q   <= 1'b0;
      instr_ret_q <= '0;
    end else begin
      if (state_d == ST_TRAP) illegal_q <= 1'b1;
      if (retire_c)           instr_ret_q <= instr_ret_q + CNT_W'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!legal_c) begin
          state_d = ST_TRAP;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_d = ST_MEMADR;
            OP_RTYPE:          state_d = ST_EXECR;
            OP_ITYPE:          state_d = ST_EXECI;
            OP_BRANCH:         state_d = ST_BRANCH;
            OP_JAL:            state_d = ST_JAL;
            OP_JALR:           state_d = ST_JALR;
            OP_AUIPC:          state_d = ST_AUIPC;
            OP_LUI:            state_d = ST_LUI;
            default:           state_d = ST_TRAP;
          endcase
        end
      end
      ST_MEMADR:   state_d = op[5] ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JAL:      state_d = ST_ALUWB;
      ST_JALR:     state_d = ST_JALRPC;
      ST_JALRPC:   state_d = ST_ALUWB;
      ST_AUIPC:    state_d = ST_ALUWB;
      ST_LUI:      state_d = ST_ALUWB;
      ST_TRAP:     state_d = ST_TRAP;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Per-state outputs; reset forces every enable and the retire strobe low.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    retire_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      ST_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      ST_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        RegWrite  = 1'b1;
        retire_c  = 1'b1;
      end
      ST_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = mem_ready;
        retire_c = mem_ready;
      end
      ST_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        RegWrite = 1'b1;
        retire_c = 1'b1;
      end
      ST_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUOp    = ALUOP_BRANCH;
        PCWrite  = Zero;
        retire_c = 1'b1;
      end
      ST_JAL, ST_JALRPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      ST_JALR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      ST_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      ST_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
      end
      ST_TRAP: ;
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire_c = 1'b0;
    end
  end

endmodule
